// File: rtl/linebuf_seq_pkg.sv
// Shared types and constants for the line-buffer window sequencer.
package linebuf_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } lb_state_e;

  localparam int unsigned LB_NUM_LINE_DEF = 4;
  localparam int unsigned LB_AWIDTH_DEF   = 11;
  localparam int unsigned LB_HWIDTH_DEF   = 11;

  // Index of the line that feeds the window centre.
  localparam int unsigned LB_CENTRE = LB_NUM_LINE_DEF / 2;

  function automatic int unsigned lb_centre(input int unsigned num_line);
    return num_line / 2;
  endfunction

endpackage

// File: rtl/lb_col_row_counter.sv
// Column/row counters for the line-buffer sequencer with row-end strobe.
module lb_col_row_counter #(
  parameter int unsigned AWIDTH = 11,
  parameter int unsigned HWIDTH = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clken,
  input  logic              clear,
  input  logic              active,
  input  logic              in_flush,
  input  logic [AWIDTH-1:0] width_q,
  output logic [AWIDTH-1:0] col,
  output logic [HWIDTH-1:0] row,
  output logic [HWIDTH-1:0] flush_row,
  output logic              last_col,
  output logic              row_end
);

  logic [AWIDTH-1:0] col_q, col_d;
  logic [HWIDTH-1:0] row_q, row_d;
  logic [HWIDTH-1:0] flush_row_q, flush_row_d;

  assign last_col  = (col_q == (width_q - AWIDTH'(1)));
  assign row_end   = active & clken & last_col;
  assign col       = col_q;
  assign row       = row_q;
  assign flush_row = flush_row_q;

  // Advance column on each active pixel strobe; bump row/flush row at row end.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    flush_row_d = flush_row_q;
    if (clear) begin
      col_d       = '0;
      row_d       = '0;
      flush_row_d = '0;
    end else if (active && clken) begin
      if (last_col) begin
        col_d = '0;
        if (in_flush) flush_row_d = flush_row_q + HWIDTH'(1);
        else          row_d       = row_q + HWIDTH'(1);
      end else begin
        col_d = col_q + AWIDTH'(1);
      end
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      flush_row_q <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      flush_row_q <= flush_row_d;
    end
  end

endmodule

// File: rtl/linebuf_window_sequencer.sv
// Line-buffer window sequencer: address/write-enable generation, line valid
// tracking, trailing-row flush and frame strobes.
// Optional: define LB_SEQ_ERR_EN for the sticky configuration/protocol error flag.
module linebuf_window_sequencer
  import linebuf_seq_pkg::*;
#(
  parameter int unsigned NUM_LINE = LB_NUM_LINE_DEF,
  parameter int unsigned AWIDTH   = LB_AWIDTH_DEF,
  parameter int unsigned HWIDTH   = LB_HWIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clken,
  input  logic                start,
  input  logic [AWIDTH-1:0]   img_width,
  input  logic [HWIDTH-1:0]   img_height,
  output logic [AWIDTH-1:0]   wr_addr,
  output logic [AWIDTH-1:0]   rd_addr,
  output logic [NUM_LINE-1:0] wr_en,
  output logic [NUM_LINE-1:0] line_valid,
  output logic                flush,
  output logic                window_valid,
  output logic                busy,
  output logic                frame_done,
  output logic                err
);

  localparam int unsigned CENTRE = lb_centre(NUM_LINE);

  lb_state_e           state_q, state_d;
  logic [AWIDTH-1:0]   width_q, width_d;
  logic [HWIDTH-1:0]   height_q, height_d;
  logic [NUM_LINE-1:0] line_valid_q, line_valid_d;
  logic                err_q, err_d;

  logic [AWIDTH-1:0]   col;
  logic [HWIDTH-1:0]   row;
  logic [HWIDTH-1:0]   flush_row;
  logic                last_col;
  logic                row_end;
  logic                active;
  logic                cfg_bad;
  logic                start_accept;

  assign active = (state_q == ST_FILL) || (state_q == ST_RUN) || (state_q == ST_FLUSH);

`ifdef LB_SEQ_ERR_EN
  // img_width is AWIDTH bits wide, so it can never exceed 2**AWIDTH.
  assign cfg_bad = (img_width < AWIDTH'(2)) || (img_height == '0);
`else
  assign cfg_bad = 1'b0;
`endif

  assign start_accept = (state_q == ST_IDLE) && start && !cfg_bad;

  lb_col_row_counter #(
    .AWIDTH (AWIDTH),
    .HWIDTH (HWIDTH)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .clken     (clken),
    .clear     (start_accept),
    .active    (active),
    .in_flush  (state_q == ST_FLUSH),
    .width_q   (width_q),
    .col       (col),
    .row       (row),
    .flush_row (flush_row),
    .last_col  (last_col),
    .row_end   (row_end)
  );

  // Next-state, configuration latch, line-valid shift and error flag.
  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    height_d     = height_q;
    line_valid_d = line_valid_q;
    err_d        = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start_accept) begin
          width_d      = img_width;
          height_d     = img_height;
          line_valid_d = '0;
          state_d      = ST_FILL;
        end
      end
      ST_FILL, ST_RUN: begin
        if (row_end) begin
          line_valid_d = {1'b1, line_valid_q[NUM_LINE-1:1]};
          if (row == (height_q - HWIDTH'(1))) state_d = ST_FLUSH;
          else if ((state_q == ST_FILL) && line_valid_d[CENTRE]) state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (row_end) begin
          line_valid_d = {1'b0, line_valid_q[NUM_LINE-1:1]};
          if (flush_row == HWIDTH'(CENTRE - 1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
`ifdef LB_SEQ_ERR_EN
    if (start && ((state_q != ST_IDLE) || cfg_bad)) err_d = 1'b1;
`else
    err_d = 1'b0;
`endif
  end

  // State and configuration registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      width_q      <= '0;
      height_q     <= '0;
      line_valid_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      width_q      <= width_d;
      height_q     <= height_d;
      line_valid_q <= line_valid_d;
      err_q        <= err_d;
    end
  end

  // Output decode from registered state; rd_addr forced to 0 while idle.
  always_comb begin
    wr_addr      = col;
    rd_addr      = '0;
    if ((state_q != ST_IDLE) && !last_col) rd_addr = col + AWIDTH'(1);
    wr_en        = active ? ({1'b1, line_valid_q[NUM_LINE-1:1]} & {NUM_LINE{clken}}) : '0;
    line_valid   = line_valid_q;
    flush        = (state_q == ST_FLUSH);
    window_valid = clken & line_valid_q[CENTRE] & active;
    busy         = (state_q != ST_IDLE);
    frame_done   = (state_q == ST_DONE);
    err          = err_q;
  end

endmodule

// File: tb/tb_linebuf_window_sequencer.sv
// Self-checking bench for linebuf_window_sequencer (NUM_LINE=4).
module tb_linebuf_window_sequencer;

  localparam int NL = 4;
  localparam int AW = 11;
  localparam int HW = 11;

  logic          clk;
  logic          rst;
  logic          clken;
  logic          start;
  logic [AW-1:0] img_width;
  logic [HW-1:0] img_height;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [NL-1:0] wr_en;
  logic [NL-1:0] line_valid;
  logic          flush;
  logic          window_valid;
  logic          busy;
  logic          frame_done;
  logic          err;

  linebuf_window_sequencer #(
    .NUM_LINE (NL),
    .AWIDTH   (AW),
    .HWIDTH   (HW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clken        (clken),
    .start        (start),
    .img_width    (img_width),
    .img_height   (img_height),
    .wr_addr      (wr_addr),
    .rd_addr      (rd_addr),
    .wr_en        (wr_en),
    .line_valid   (line_valid),
    .flush        (flush),
    .window_valid (window_valid),
    .busy         (busy),
    .frame_done   (frame_done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [NL-1:0] wr_en;
    logic [NL-1:0] line_valid;
    logic          flush;
    logic          wv;
    logic          busy;
    logic          fd;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   wv_seen  = 0;
  logic exp_err  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs at input row r (rows >= h are flush rows), column c.
  // Line bit k holds the row written (NL-k) row ends ago; it is valid when
  // that row index was a real input row.
  function automatic exp_t make_exp(input int w, input int h, input int r, input int c, input bit ce);
    exp_t e;
    for (int k = 0; k < NL; k++) begin
      int j;
      j = r - NL + k;
      e.line_valid[k] = (j >= 0) && (j < h);
    end
    e.wr_en[NL-1] = ce;
    for (int k = 0; k < NL - 1; k++) e.wr_en[k] = ce & e.line_valid[k+1];
    e.wv      = ce & e.line_valid[NL/2];
    e.flush   = (r >= h);
    e.busy    = 1'b1;
    e.fd      = 1'b0;
    e.wr_addr = AW'(c);
    e.rd_addr = (c == w - 1) ? '0 : AW'(c + 1);
    e.err     = exp_err;
    return e;
  endfunction

  task automatic compare_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty got=0 exp=1");
      return;
    end
    e = exp_q.pop_front();
    check_eq("wr_addr",      32'(wr_addr),      32'(e.wr_addr));
    check_eq("rd_addr",      32'(rd_addr),      32'(e.rd_addr));
    check_eq("wr_en",        32'(wr_en),        32'(e.wr_en));
    check_eq("line_valid",   32'(line_valid),   32'(e.line_valid));
    check_eq("flush",        32'(flush),        32'(e.flush));
    check_eq("window_valid", 32'(window_valid), 32'(e.wv));
    check_eq("busy",         32'(busy),         32'(e.busy));
    check_eq("frame_done",   32'(frame_done),   32'(e.fd));
    check_eq("err",          32'(err),          32'(e.err));
    if (window_valid === 1'b1) wv_seen++;
  endtask

  // Called at a negedge; drives one cycle, checks, returns at next negedge.
  task automatic step(input exp_t e, input bit ce, input bit st);
    clken = ce;
    start = st;
    exp_q.push_back(e);
    #1;
    compare_out();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check_eq({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check_eq({tag, "_wr_en"},   32'(wr_en),   32'd0);
    check_eq({tag, "_lv"},      32'(line_valid), 32'd0);
    check_eq({tag, "_flush"},   32'(flush),   32'd0);
    check_eq({tag, "_wv"},      32'(window_valid), 32'd0);
    check_eq({tag, "_busy"},    32'(busy),    32'd0);
    check_eq({tag, "_fd"},      32'(frame_done), 32'd0);
    check_eq({tag, "_err"},     32'(err),     32'd0);
  endtask

  task automatic run_frame(input int w, input int h, input bit toggle,
                           input int abort_r, input int abort_c, input bit mid_start);
    start      = 1'b1;
    img_width  = AW'(w);
    img_height = HW'(h);
    clken      = 1'b0;
    @(negedge clk);
    start   = 1'b0;
    wv_seen = 0;
    for (int r = 0; r < h + NL / 2; r++) begin
      for (int c = 0; c < w; c++) begin
        bit st;
        if (r == abort_r && c == abort_c) begin
          rst   = 1'b1;
          clken = 1'b1;
          @(negedge clk);
          rst     = 1'b0;
          exp_err = 1'b0;
          #1;
          check_all_zero("abort");
          for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check_eq("abort_no_done", 32'(frame_done), 32'd0);
            check_eq("abort_idle",    32'(busy),       32'd0);
          end
          @(negedge clk);
          return;
        end
        if (toggle) step(make_exp(w, h, r, c, 1'b0), 1'b0, 1'b0);
        st = mid_start && (r == 1) && (c == 3);
        step(make_exp(w, h, r, c, 1'b1), 1'b1, st);
`ifdef LB_SEQ_ERR_EN
        if (st) exp_err = 1'b1;
`endif
      end
    end
    clken = 1'b1;
    #1;
    check_eq("done_pulse", 32'(frame_done),   32'd1);
    check_eq("done_busy",  32'(busy),         32'd1);
    check_eq("done_wr_en", 32'(wr_en),        32'd0);
    check_eq("done_wv",    32'(window_valid), 32'd0);
    check_eq("done_flush", 32'(flush),        32'd0);
    @(negedge clk);
    #1;
    check_eq("post_busy", 32'(busy),       32'd0);
    check_eq("post_done", 32'(frame_done), 32'd0);
    check_eq("wv_count",  32'(wv_seen),    32'(w * h));
    @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    clken      = 1'b0;
    start      = 1'b0;
    img_width  = '0;
    img_height = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_frame(8, 4, 1'b0, -1, -1, 1'b0);
    run_frame(8, 4, 1'b1, -1, -1, 1'b0);
    run_frame(8, 1, 1'b0, -1, -1, 1'b0);
    run_frame(8, 4, 1'b0, 2, 5, 1'b0);
    run_frame(8, 4, 1'b0, -1, -1, 1'b0);
    run_frame(5, 3, 1'b1, -1, -1, 1'b0);
    run_frame(6, 2, 1'b0, -1, -1, 1'b1);

`ifdef LB_SEQ_ERR_EN
    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    exp_err = 1'b0;
    start      = 1'b1;
    img_width  = AW'(1);
    img_height = HW'(4);
    @(negedge clk);
    start = 1'b0;
    #1;
    check_eq("bad_cfg_err",  32'(err),  32'd1);
    check_eq("bad_cfg_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    exp_err = 1'b0;
    run_frame(8, 3, 1'b0, -1, -1, 1'b1);
    check_eq("busy_start_err", 32'(err), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/linebuf_window_sequencer.md
Name: linebuf_window_sequencer

Overview:
Sequences the NUM_LINE-deep dual-port line-buffer SRAM behind the post-processing window buffers (disparity L/R, confidence) for one frame. It generates write/read addresses and per-line write enables, and tracks per-line valid bits. It flushes NUM_LINE/2 trailing rows at end of frame so the bottom image rows still reach the window centre. It also emits window-valid and frame-done strobes to the downstream window filter.

Parameters:
NUM_LINE, 4, line buffers in the SRAM; even, >=2
AWIDTH, 11, address/column width; img_width <= 2**AWIDTH
HWIDTH, 11, row counter/img_height width

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
clken  input  1  pixel strobe; all counters advance only when high
start  input  1  frame start pulse; sampled in IDLE regardless of clken
img_width  input  AWIDTH  pixels per row, latched at start
img_height  input  HWIDTH  rows per frame, latched at start
wr_addr  output  AWIDTH  SRAM port-A address (current column)
rd_addr  output  AWIDTH  SRAM port-B address (next column, 1-cycle read prefetch)
wr_en  output  NUM_LINE  per-line write enable
line_valid  output  NUM_LINE  line i holds valid data
flush  output  1  high during trailing rows; upstream must drive zero pixels
window_valid  output  1  current clken cycle produces a valid window centre pixel
busy  output  1  state != IDLE
frame_done  output  1  one-cycle pulse at end of frame
err  output  1  sticky configuration/protocol error (see Optional Feature)

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - State=IDLE.
  - col, row, flush_row, line_valid and the latched width/height clear to 0.
  - All outputs are 0.
  - rst mid-frame aborts the frame. frame_done is not pulsed.
- States:
  - IDLE: start=1 → latch img_width/img_height, col=0, row=0, line_valid=0, go to FILL. Otherwise hold.
  - FILL: input rows, centre line not yet valid. When line_valid[NUM_LINE/2] becomes 1, go to RUN.
  - RUN: steady state.
  - FLUSH: NUM_LINE/2 extra rows with zero input.
  - DONE: one cycle, frame_done=1, then go to IDLE.
- Column and row counting (FILL/RUN/FLUSH, clken=1):
  - col increments. At col==width_q-1 it wraps to 0 (row end).
  - At row end: line_valid <= {in_bit, line_valid[NUM_LINE-1:1]}. in_bit is 1 in FILL/RUN and 0 in FLUSH.
  - At row end in FILL/RUN: row increments.
  - At row end in FLUSH: flush_row increments.
- Exit conditions:
  - Row end with row==height_q-1 (FILL or RUN) → FLUSH. This applies even if still in FILL (short frames).
  - Row end in FLUSH with flush_row==NUM_LINE/2-1 → DONE.
- clken=0: all state, counters and addresses hold.
- Addresses:
  - wr_addr = col.
  - rd_addr = (col==width_q-1) ? 0 : col+1.
  - Both are combinational from registered col, so the SRAM dout aligns with the next write.
- wr_en:
  - wr_en = {1'b1, line_valid[NUM_LINE-1:1]} & {NUM_LINE{clken}}.
  - Gated to 0 in IDLE and DONE.
- window_valid = clken & line_valid[NUM_LINE/2] & (state in FILL/RUN/FLUSH).
  - Invariant: exactly width_q*height_q pulses per frame.
- flush = (state==FLUSH).
- busy = (state != IDLE).
- Edge cases:
  - start while busy: ignored.
  - start and rst together: rst wins.
  - Row end and last row together: line_valid shifts and state moves in the same cycle.

Optional Feature:
LB_SEQ_ERR_EN. When defined, err is a sticky flag, cleared only by rst. It sets when:
- start is accepted with img_width<2, img_height==0, or img_width>2**AWIDTH. The frame is then rejected and state stays IDLE.
- start arrives while busy.

When not defined, err is tied to 0, no width/height checks are made, and invalid configurations are undefined behaviour.

Decomposition:
- Package linebuf_seq_pkg:
  - state enum (IDLE, FILL, RUN, FLUSH, DONE);
  - LB_CENTRE = NUM_LINE/2;
  - default width constants.
- Sub-module lb_col_row_counter: col/row counters with wrap and row-end strobe. The FSM, line_valid shift register and output decode stay in the top module.

Test Plan:
- NUM_LINE=4, width=8, height=4, clken=1 continuous, start pulse:
  - line_valid goes 1000→1100→1110 at row ends;
  - window_valid first asserts at input row 2, col 0;
  - exactly 32 window_valid pulses;
  - flush high for 16 cycles;
  - frame_done pulses once; busy drops the next cycle.
- Same config, clken toggling 1/0: all outputs hold on clken=0 cycles; pulse counts identical (32).
- width=8, height=1:
  - FILL → FLUSH directly;
  - line_valid 1000→0100→0010;
  - 8 window_valid pulses, all during FLUSH.
- Address check, width=8: rd_addr = wr_addr+1, and at wr_addr=7 rd_addr=0; wr_en[3]=1 every active clken cycle.
- rst asserted mid-RUN (row 2, col 5): next cycle state IDLE, all outputs 0, no frame_done. A new start runs a full correct frame.
- With LB_SEQ_ERR_EN:
  - start with width=1 → err=1, busy stays 0;
  - start during busy → err=1, frame continues unaffected.
